// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: IF / LSU / loader share one word memory, with a lock FSM for program download.
// Optional IF starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned MEM_ADDR_W = 32,
    parameter int unsigned WORD_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic                  lsu_req_i,
    input  logic                  ldr_req_i,
    input  logic [MEM_ADDR_W-1:0] if_addr_i,
    input  logic [MEM_ADDR_W-1:0] lsu_addr_i,
    input  logic [MEM_ADDR_W-1:0] ldr_addr_i,
    input  logic                  lsu_we_i,
    input  logic                  ldr_we_i,
    input  logic [WORD_W-1:0]     lsu_wdata_i,
    input  logic [WORD_W-1:0]     ldr_wdata_i,
    input  logic [3:0]            lsu_sel_i,
    input  logic [3:0]            ldr_sel_i,
    output logic                  if_gnt_o,
    output logic                  lsu_gnt_o,
    output logic                  ldr_gnt_o,
    output logic                  if_rvalid_o,
    output logic                  lsu_rvalid_o,
    output logic                  ldr_rvalid_o,
    output logic [WORD_W-1:0]     rdata_o,
    input  logic                  ldr_lock_i,
    output logic                  ldr_lock_ack_o,
    output logic [MEM_ADDR_W-1:0] mem_r_addr_o,
    output logic [MEM_ADDR_W-1:0] mem_w_addr_o,
    output logic                  mem_w_en_o,
    output logic [WORD_W-1:0]     mem_w_data_o,
    output logic [3:0]            mem_w_sel_o,
    input  logic [WORD_W-1:0]     mem_r_data_i
);

    typedef enum logic [1:0] {
        NORMAL,
        DRAIN,
        LOCKED
    } state_e;

    state_e state_q, state_d;

    logic              if_prio;
    logic              if_rvalid_q, lsu_rvalid_q, ldr_rvalid_q;
    logic              if_rvalid_d, lsu_rvalid_d, ldr_rvalid_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign if_prio = (starve_q == STARVE_LIM);

    always_comb begin
        starve_d = starve_q;
        if (if_gnt_o || state_q != NORMAL || state_d != NORMAL) begin
            starve_d = '0;
        end else if (if_req_i && starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign if_prio = 1'b0;
`endif

    // Grants are combinational; the lock-request cycle may still grant, DRAIN lets that read return.
    always_comb begin
        state_d   = state_q;
        if_gnt_o  = 1'b0;
        lsu_gnt_o = 1'b0;
        ldr_gnt_o = 1'b0;
        unique case (state_q)
            NORMAL: begin
                if (lsu_req_i && !(if_req_i && if_prio)) begin
                    lsu_gnt_o = 1'b1;
                end else if (if_req_i) begin
                    if_gnt_o = 1'b1;
                end
                if (ldr_lock_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = LOCKED;
            end
            LOCKED: begin
                if (ldr_lock_i) begin
                    ldr_gnt_o = ldr_req_i;
                end else begin
                    state_d = NORMAL;
                end
            end
            default: begin
                state_d = NORMAL;
            end
        endcase
    end

    always_comb begin
        mem_r_addr_o = '0;
        mem_w_addr_o = '0;
        mem_w_en_o   = 1'b0;
        mem_w_data_o = '0;
        mem_w_sel_o  = '0;
        if (lsu_gnt_o) begin
            mem_r_addr_o = lsu_addr_i;
            mem_w_addr_o = lsu_addr_i;
            mem_w_en_o   = lsu_we_i;
            mem_w_data_o = lsu_wdata_i;
            mem_w_sel_o  = lsu_we_i ? lsu_sel_i : 4'b0000;
        end else if (if_gnt_o) begin
            mem_r_addr_o = if_addr_i;
            mem_w_addr_o = if_addr_i;
        end else if (ldr_gnt_o) begin
            mem_r_addr_o = ldr_addr_i;
            mem_w_addr_o = ldr_addr_i;
            mem_w_en_o   = ldr_we_i;
            mem_w_data_o = ldr_wdata_i;
            mem_w_sel_o  = ldr_we_i ? ldr_sel_i : 4'b0000;
        end
    end

    always_comb begin
        if_rvalid_d  = if_gnt_o;
        lsu_rvalid_d = lsu_gnt_o && !lsu_we_i;
        ldr_rvalid_d = ldr_gnt_o && !ldr_we_i;
        rdata_d      = rdata_q;
        if (if_rvalid_d || lsu_rvalid_d || ldr_rvalid_d) begin
            rdata_d = mem_r_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= NORMAL;
            if_rvalid_q  <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            if_rvalid_q  <= if_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            ldr_rvalid_q <= ldr_rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign if_rvalid_o    = if_rvalid_q;
    assign lsu_rvalid_o   = lsu_rvalid_q;
    assign ldr_rvalid_o   = ldr_rvalid_q;
    assign rdata_o        = rdata_q;
    assign ldr_lock_ack_o = (state_q == LOCKED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-lane word memory model behind the memory port.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, lsu_req, ldr_req;
    logic [31:0] if_addr, lsu_addr, ldr_addr;
    logic        lsu_we, ldr_we;
    logic [31:0] lsu_wdata, ldr_wdata;
    logic [3:0]  lsu_sel, ldr_sel;
    logic        if_gnt, lsu_gnt, ldr_gnt;
    logic        if_rvalid, lsu_rvalid, ldr_rvalid;
    logic [31:0] rdata;
    logic        ldr_lock, ldr_lock_ack;
    logic [31:0] mem_r_addr, mem_w_addr, mem_w_data, mem_r_data;
    logic        mem_w_en;
    logic [3:0]  mem_w_sel;

    logic [31:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    int nchk  = 0;
    int nfail = 0;
    bit guard_on;

    mem_port_arbiter #(.STARVE_MAX(4), .MEM_ADDR_W(32), .WORD_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .lsu_req_i(lsu_req), .ldr_req_i(ldr_req),
        .if_addr_i(if_addr), .lsu_addr_i(lsu_addr), .ldr_addr_i(ldr_addr),
        .lsu_we_i(lsu_we), .ldr_we_i(ldr_we),
        .lsu_wdata_i(lsu_wdata), .ldr_wdata_i(ldr_wdata),
        .lsu_sel_i(lsu_sel), .ldr_sel_i(ldr_sel),
        .if_gnt_o(if_gnt), .lsu_gnt_o(lsu_gnt), .ldr_gnt_o(ldr_gnt),
        .if_rvalid_o(if_rvalid), .lsu_rvalid_o(lsu_rvalid), .ldr_rvalid_o(ldr_rvalid),
        .rdata_o(rdata),
        .ldr_lock_i(ldr_lock), .ldr_lock_ack_o(ldr_lock_ack),
        .mem_r_addr_o(mem_r_addr), .mem_w_addr_o(mem_w_addr),
        .mem_w_en_o(mem_w_en), .mem_w_data_o(mem_w_data), .mem_w_sel_o(mem_w_sel),
        .mem_r_data_i(mem_r_data)
    );

    always #5 clk = ~clk;

    assign mem_r_data = mem[mem_r_addr[7:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_w_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_w_sel[b]) mem[mem_w_addr[7:2]][8*b +: 8] <= mem_w_data[8*b +: 8];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        guard_on = 1'b1;
`else
        guard_on = 1'b0;
`endif
        rst = 1'b1;
        if_req = 0; lsu_req = 0; ldr_req = 0;
        if_addr = '0; lsu_addr = '0; ldr_addr = '0;
        lsu_we = 0; ldr_we = 0; lsu_wdata = '0; ldr_wdata = '0;
        lsu_sel = '0; ldr_sel = '0; ldr_lock = 0;
        pl_en = 1'b1; pl_idx = 6'd4; pl_data = 32'hDEAD_BEEF;
        cyc();
        pl_idx = 6'd8; pl_data = 32'hAABB_CCDD;
        cyc();
        pl_en = 1'b0;
        #1;
        chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
        chk("rst_lsu_gnt", {31'b0, lsu_gnt}, 32'd0);
        chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        chk("rst_lsu_rvalid", {31'b0, lsu_rvalid}, 32'd0);
        chk("rst_ldr_rvalid", {31'b0, ldr_rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ack", {31'b0, ldr_lock_ack}, 32'd0);
        chk("rst_w_en", {31'b0, mem_w_en}, 32'd0);
        chk("rst_w_sel", {28'b0, mem_w_sel}, 32'd0);
        chk("rst_r_addr", mem_r_addr, 32'd0);
        chk("rst_w_addr", mem_w_addr, 32'd0);
        rst = 1'b0;
        cyc();

        // isolated IF read
        if_req = 1; if_addr = 32'h10;
        #1;
        chk("if_gnt", {31'b0, if_gnt}, 32'd1);
        chk("if_r_addr", mem_r_addr, 32'h10);
        chk("if_w_en", {31'b0, mem_w_en}, 32'd0);
        cyc();
        if_req = 0;
        #1;
        chk("if_rvalid", {31'b0, if_rvalid}, 32'd1);
        chk("if_rdata", rdata, 32'hDEAD_BEEF);
        chk("if_lsu_rvalid", {31'b0, lsu_rvalid}, 32'd0);
        cyc();
        chk("if_rvalid_pulse", {31'b0, if_rvalid}, 32'd0);

        // LSU byte write then read-back
        lsu_req = 1; lsu_we = 1; lsu_addr = 32'h20; lsu_wdata = 32'h1122_3344; lsu_sel = 4'b0101;
        #1;
        chk("wr_gnt", {31'b0, lsu_gnt}, 32'd1);
        chk("wr_w_en", {31'b0, mem_w_en}, 32'd1);
        chk("wr_w_sel", {28'b0, mem_w_sel}, 32'h5);
        chk("wr_w_addr", mem_w_addr, 32'h20);
        cyc();
        lsu_we = 0;
        #1;
        chk("rd_gnt", {31'b0, lsu_gnt}, 32'd1);
        chk("wr_no_rvalid", {31'b0, lsu_rvalid}, 32'd0);
        chk("rd_w_sel", {28'b0, mem_w_sel}, 32'd0);
        cyc();
        lsu_req = 0;
        #1;
        chk("rd_rvalid", {31'b0, lsu_rvalid}, 32'd1);
        chk("rd_rdata", rdata, 32'hAA22_CC44);
        cyc();

        // IF/LSU contention
        if_req = 1; if_addr = 32'h10;
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h20;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("cont_if_gnt_%0d", i), {31'b0, if_gnt}, {31'b0, guard_on && i == 4});
            chk($sformatf("cont_lsu_gnt_%0d", i), {31'b0, lsu_gnt}, {31'b0, !(guard_on && i == 4)});
            cyc();
        end
        if_req = 0; lsu_req = 0;
        cyc();

        // lock rises during an LSU read grant
        lsu_req = 1; lsu_addr = 32'h10; ldr_lock = 1;
        #1;
        chk("lock_lsu_gnt", {31'b0, lsu_gnt}, 32'd1);
        chk("lock_ack0", {31'b0, ldr_lock_ack}, 32'd0);
        cyc();
        if_req = 1; ldr_req = 1; ldr_we = 1; ldr_addr = 32'h0; ldr_wdata = 32'h0000_0013; ldr_sel = 4'hF;
        #1;
        chk("drain_lsu_rvalid", {31'b0, lsu_rvalid}, 32'd1);
        chk("drain_rdata", rdata, 32'hDEAD_BEEF);
        chk("drain_gnts", {29'b0, if_gnt, lsu_gnt, ldr_gnt}, 32'd0);
        chk("drain_ack", {31'b0, ldr_lock_ack}, 32'd0);
        cyc();
        chk("locked_ack", {31'b0, ldr_lock_ack}, 32'd1);
        chk("locked_gnts", {29'b0, if_gnt, lsu_gnt, ldr_gnt}, 32'd1);
        chk("locked_w_en", {31'b0, mem_w_en}, 32'd1);
        chk("locked_w_sel", {28'b0, mem_w_sel}, 32'hF);
        chk("locked_w_addr", mem_w_addr, 32'h0);
        cyc();
        ldr_we = 0;
        #1;
        chk("ldr_rd_gnt", {31'b0, ldr_gnt}, 32'd1);
        chk("ldr_wr_no_rvalid", {31'b0, ldr_rvalid}, 32'd0);
        cyc();
        ldr_req = 0; lsu_req = 0;
        #1;
        chk("ldr_rvalid", {31'b0, ldr_rvalid}, 32'd1);
        chk("ldr_rdata", rdata, 32'h0000_0013);

        // lock release
        ldr_lock = 0; ldr_req = 1; if_addr = 32'h10;
        #1;
        chk("rel_ack_still", {31'b0, ldr_lock_ack}, 32'd1);
        chk("rel_no_gnt", {29'b0, if_gnt, lsu_gnt, ldr_gnt}, 32'd0);
        cyc();
        ldr_req = 0;
        #1;
        chk("rel_ack_low", {31'b0, ldr_lock_ack}, 32'd0);
        chk("rel_if_gnt", {31'b0, if_gnt}, 32'd1);
        chk("rel_ldr_rvalid", {31'b0, ldr_rvalid}, 32'd0);
        cyc();
        if_req = 0;
        #1;
        chk("rel_if_rvalid", {31'b0, if_rvalid}, 32'd1);
        chk("rel_if_rdata", rdata, 32'hDEAD_BEEF);

        // reset while a loader read is outstanding
        ldr_lock = 1;
        cyc();
        cyc();
        chk("rst2_locked", {31'b0, ldr_lock_ack}, 32'd1);
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h20;
        #1;
        chk("rst2_ldr_gnt", {31'b0, ldr_gnt}, 32'd1);
        rst = 1;
        cyc();
        rst = 0; ldr_req = 0; ldr_lock = 0;
        #1;
        chk("rst2_rvalid", {31'b0, ldr_rvalid}, 32'd0);
        chk("rst2_ack", {31'b0, ldr_lock_ack}, 32'd0);
        chk("rst2_rdata", rdata, 32'd0);
        if_req = 1; if_addr = 32'h20;
        #1;
        chk("rst2_if_gnt", {31'b0, if_gnt}, 32'd1);
        cyc();
        if_req = 0;
        #1;
        chk("rst2_if_rdata", rdata, 32'hAA22_CC44);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
